// File: rtl/security_zone_ctrl.sv
// Multi-zone door lock / intrusion alarm supervisor behind a single PIN keypad.
// Adds failed-attempt lockout, auto-relock timing and per-zone alarm latching.
module security_zone_ctrl #(
    parameter int NUM_ZONES      = 4,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int RELOCK_CYCLES  = 16,
    parameter int LOCKOUT_CYCLES = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                pin_valid,
    input  logic                                pin_correct,
    input  logic                                lock_req,
    input  logic [NUM_ZONES-1:0]                door_closed,
    input  logic [NUM_ZONES-1:0]                intruder_detected,
    output logic                                lock_state,
    output logic                                alarm_state,
    output logic                                lockout_state,
    output logic [NUM_ZONES-1:0]                alarm_zone,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0]   fail_count,
    output logic [1:0]                          dbg_state
);

    localparam int FW = $clog2(MAX_ATTEMPTS + 1);
    localparam int RW = $clog2(RELOCK_CYCLES + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [1:0] S_LOCKED   = 2'b00;
    localparam logic [1:0] S_UNLOCKED = 2'b01;
    localparam logic [1:0] S_ALARM    = 2'b10;
    localparam logic [1:0] S_LOCKOUT  = 2'b11;

    localparam logic [FW-1:0] FAIL_MAX     = FW'(MAX_ATTEMPTS);
    localparam logic [FW-1:0] FAIL_ONE     = FW'(1);
    localparam logic [RW-1:0] RELOCK_INIT  = RW'(RELOCK_CYCLES);
    localparam logic [RW-1:0] RELOCK_ONE   = RW'(1);
    localparam logic [LW-1:0] LOCKOUT_INIT = LW'(LOCKOUT_CYCLES);
    localparam logic [LW-1:0] LOCKOUT_ONE  = LW'(1);

    logic [1:0]           r_state;
    logic [FW-1:0]        r_fail;
    logic [NUM_ZONES-1:0] r_zone;
    logic [RW-1:0]        r_relock;
    logic [LW-1:0]        r_lockout;

    logic [1:0]           w_state_nxt;
    logic [FW-1:0]        w_fail_nxt;
    logic [NUM_ZONES-1:0] w_zone_nxt;
    logic [RW-1:0]        w_relock_nxt;
    logic [LW-1:0]        w_lockout_nxt;

    logic w_any_intr;
    logic w_all_closed;
    logic w_good;
    logic w_bad;

    assign w_any_intr   = |intruder_detected;
    assign w_all_closed = &door_closed;
    assign w_good       = pin_valid & pin_correct;
    assign w_bad        = pin_valid & ~pin_correct;

    always_comb begin
        w_state_nxt   = r_state;
        w_fail_nxt    = r_fail;
        w_zone_nxt    = r_zone;
        w_relock_nxt  = r_relock;
        w_lockout_nxt = r_lockout;
        case (r_state)
            S_LOCKED: begin
                if (w_any_intr) begin
                    w_state_nxt = S_ALARM;
                    w_zone_nxt  = intruder_detected;
                end else if (w_good && w_all_closed) begin
                    w_state_nxt  = S_UNLOCKED;
                    w_fail_nxt   = '0;
                    w_relock_nxt = RELOCK_INIT;
                end else if (w_bad) begin
                    // The attempt that reaches the limit is the one that locks the keypad out.
                    if (r_fail >= FAIL_MAX - FAIL_ONE) begin
                        w_state_nxt   = S_LOCKOUT;
                        w_fail_nxt    = FAIL_MAX;
                        w_lockout_nxt = LOCKOUT_INIT;
                    end else begin
                        w_fail_nxt = r_fail + FAIL_ONE;
                    end
                end
            end
            S_UNLOCKED: begin
                if (w_any_intr) begin
                    w_state_nxt  = S_ALARM;
                    w_zone_nxt   = intruder_detected;
                    w_relock_nxt = '0;
                end else if (lock_req && w_all_closed) begin
                    w_state_nxt  = S_LOCKED;
                    w_relock_nxt = '0;
                end else if (!w_all_closed) begin
                    w_relock_nxt = RELOCK_INIT;
                end else if (r_relock <= RELOCK_ONE) begin
                    w_state_nxt  = S_LOCKED;
                    w_relock_nxt = '0;
                end else begin
                    w_relock_nxt = r_relock - RELOCK_ONE;
                end
            end
            S_ALARM: begin
                // A correct PIN clears the alarm even if a sensor fires in the same cycle.
                if (w_good) begin
                    w_state_nxt = S_LOCKED;
                    w_zone_nxt  = '0;
                    w_fail_nxt  = '0;
                end else begin
                    w_zone_nxt = r_zone | intruder_detected;
                    if (w_bad && (r_fail < FAIL_MAX)) begin
                        w_fail_nxt = r_fail + FAIL_ONE;
                    end
                end
            end
            default: begin
                if (w_any_intr) begin
                    w_state_nxt   = S_ALARM;
                    w_zone_nxt    = intruder_detected;
                    w_lockout_nxt = '0;
                end else if (r_lockout <= LOCKOUT_ONE) begin
                    w_state_nxt   = S_LOCKED;
                    w_fail_nxt    = '0;
                    w_lockout_nxt = '0;
                end else begin
                    w_lockout_nxt = r_lockout - LOCKOUT_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_LOCKED;
            r_fail    <= '0;
            r_zone    <= '0;
            r_relock  <= '0;
            r_lockout <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_fail    <= w_fail_nxt;
            r_zone    <= w_zone_nxt;
            r_relock  <= w_relock_nxt;
            r_lockout <= w_lockout_nxt;
        end
    end

    assign lock_state    = (r_state != S_UNLOCKED);
    assign alarm_state   = (r_state == S_ALARM);
    assign lockout_state = (r_state == S_LOCKOUT);
    assign alarm_zone    = r_zone;
    assign fail_count    = r_fail;
    assign dbg_state     = r_state;

endmodule

// File: doc/security_zone_ctrl.md
Name: security_zone_ctrl

Overview:
- Parametrised successor to the single-door lock/alarm FSM for the smart-city building model.
- Supervises NUM_ZONES doors/intrusion sensors behind one PIN keypad.
- Adds qualified PIN strobes, a failed-attempt counter with timed lockout, an auto-relock timer and per-zone alarm latching.
- Sits between the keypad/sensor stubs and the building status aggregator. All outputs are Moore (decoded from registered state).

Parameters:
- NUM_ZONES, 4: number of door/sensor zones (>=1).
- MAX_ATTEMPTS, 3: consecutive wrong PINs that trigger lockout (>=1).
- RELOCK_CYCLES, 16: cycles with all doors closed in UNLOCKED before automatic relock (>=1).
- LOCKOUT_CYCLES, 32: duration of the LOCKOUT state in cycles (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- pin_valid  input  1  one-cycle strobe: a PIN entry is complete this cycle.
- pin_correct  input  1  PIN result; meaningful only when pin_valid=1.
- lock_req  input  1  manual relock request, sampled in UNLOCKED.
- door_closed  input  NUM_ZONES  1 = zone door closed.
- intruder_detected  input  NUM_ZONES  1 = intrusion sensed in zone.
- lock_state  output  1  door bolts engaged (1 in every state except UNLOCKED).
- alarm_state  output  1  1 while in ALARM.
- lockout_state  output  1  1 while in LOCKOUT.
- alarm_zone  output  NUM_ZONES  sticky record of zones that raised or joined the current alarm.
- fail_count  output  $clog2(MAX_ATTEMPTS+1)  consecutive wrong-PIN count.

Behaviour:
- Reset (rst=0 at a clk edge):
  - State LOCKED; fail_count=0; alarm_zone=0; both timers 0.
  - Outputs lock_state=1, alarm_state=0, lockout_state=0.
  - Reset overrides everything, including mid-timer and mid-alarm.
- Definitions: any_intr = |intruder_detected; all_closed = &door_closed; good = pin_valid & pin_correct; bad = pin_valid & ~pin_correct.
- Latency: inputs are sampled at edge N; state and outputs change after edge N. pin_correct is ignored when pin_valid=0.
- LOCKED (priority order):
  - any_intr: go to ALARM; alarm_zone <= intruder_detected.
  - good & all_closed: go to UNLOCKED; fail_count <= 0; relock timer <= RELOCK_CYCLES.
  - good & ~all_closed: stay LOCKED, no count change.
  - bad: fail_count+1. If the new value == MAX_ATTEMPTS, go to LOCKOUT with lockout timer <= LOCKOUT_CYCLES.
- UNLOCKED (priority order):
  - any_intr: go to ALARM; latch alarm_zone.
  - Else, lock_req & all_closed: go to LOCKED.
  - Else, ~all_closed: reload relock timer to RELOCK_CYCLES.
  - Else: decrement the timer. The edge at which the timer reads 1 goes to LOCKED, so exactly RELOCK_CYCLES consecutive all-closed cycles are needed.
  - PIN strobes are ignored.
- ALARM:
  - Each cycle, alarm_zone <= alarm_zone | intruder_detected.
  - good: go to LOCKED; alarm_zone <= 0; fail_count <= 0. This takes priority over a same-cycle intruder.
  - bad: fail_count saturates at MAX_ATTEMPTS; no lockout from ALARM.
- LOCKOUT:
  - PIN strobes ignored; fail_count held.
  - any_intr: go to ALARM; latch alarm_zone; lockout timer abandoned.
  - Else: decrement the timer. The edge at which it reads 1 goes to LOCKED with fail_count <= 0. LOCKOUT lasts exactly LOCKOUT_CYCLES cycles.
- Encoding: LOCKED=00, UNLOCKED=01, ALARM=10, LOCKOUT=11. No illegal encodings exist.
- Timer widths: $clog2(max+1) bits. Counters never wrap.

Test Plan:
- Reset, then good with door_closed=4'hF → next cycle lock_state=0, fail_count=0. Hold doors closed for 16 cycles → lock_state=1 on the 16th edge.
- Three bad strobes in LOCKED → fail_count 1, 2, then lockout_state=1 with fail_count=3. Send good during lockout → ignored. After 32 cycles → LOCKED, fail_count=0.
- UNLOCKED, open door 2 at timer=3 → timer reloads, no relock. Close door; assert lock_req → LOCKED next cycle.
- LOCKED, intruder=4'b0010, then 4'b1000 → alarm_state=1, alarm_zone=4'b1010. A bad strobe keeps ALARM. good with intruder=4'b0001 in the same cycle → LOCKED, alarm_zone=0.
- LOCKOUT at timer=10, intruder=4'b0100 → ALARM, alarm_zone=4'b0100, fail_count stays 3.
- Assert rst=0 mid-ALARM → next edge LOCKED, all outputs at their reset values. Confirm that rst=0 asserted between edges has no effect until the next edge.
